// File: rtl/ccsds_ldpc_pkg.sv
// Shared definitions for the CCSDS LDPC input framer: code modes, info-block sizes,
// beats-per-frame helper and the framer state encoding.
package ccsds_ldpc_pkg;

  localparam logic [1:0] MODE_1024 = 2'd0;
  localparam logic [1:0] MODE_4096 = 2'd1;
  localparam logic [1:0] MODE_7136 = 2'd2;
  localparam logic [1:0] MODE_RSVD = 2'd3;

  localparam int K_1024 = 1024;
  localparam int K_4096 = 4096;
  localparam int K_7136 = 7136;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    PAD  = 2'd2
  } state_t;

  // Reserved mode falls back to the K=1024 block size.
  function automatic logic [12:0] nb_of(input logic [1:0] m, input int width);
    int k;
    case (m)
      MODE_4096: k = K_4096;
      MODE_7136: k = K_7136;
      default:   k = K_1024;
    endcase
    return 13'(k / width);
  endfunction

endpackage

// File: rtl/ccsds_ldpc_axis_framer_skid.sv
// Two-entry skid buffer with registered output and registered input ready; full
// throughput with no combinational path from out_ready_i to in_ready_o.
module axis_skid_buffer #(
  parameter int DW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  output logic [DW-1:0] out_data_o,
  output logic          out_valid_o,
  input  logic          out_ready_i
);

  logic [DW-1:0] out_data_q, out_data_d;
  logic [DW-1:0] skid_data_q, skid_data_d;
  logic          out_valid_q, out_valid_d;
  logic          skid_valid_q, skid_valid_d;
  logic          ready_q, ready_d;
  logic          pop;

  // in_valid_i may only be raised while in_ready_o is high, so the skid slot is free.
  always_comb begin
    pop          = out_valid_q && out_ready_i;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;
    if (!out_valid_q || pop) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = in_valid_i;
        if (in_valid_i) skid_data_d = in_data_i;
      end else begin
        out_valid_d  = in_valid_i;
        if (in_valid_i) out_data_d = in_data_i;
        skid_valid_d = 1'b0;
      end
    end else if (in_valid_i) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data_i;
    end
    ready_d = !(out_valid_d && skid_valid_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      skid_data_q  <= '0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ready_d;
    end
  end

  assign in_ready_o  = ready_q;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: rtl/ccsds_ldpc_axis_framer.sv
// Cuts the info-bit AXI stream into K-bit LDPC frames, marks the last beat with tlast
// and zero-pads frames that the upstream terminates early.
module ccsds_ldpc_axis_framer
  import ccsds_ldpc_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter logic USE_TLAST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] s_axis_tdata,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tlast,
  output logic             s_axis_tready,
  output logic [WIDTH-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  output logic [1:0]       m_axis_tuser,
  input  logic             m_axis_tready,
  output logic             err_short,
  output logic             err_long,
  output logic             err_mode,
  output logic [15:0]      frame_cnt,
  output logic [1:0]       dbg_state
);

  state_t        state_q;
  logic [12:0]   cnt_q;
  logic [1:0]    mode_q;
  logic          err_short_q, err_long_q, err_mode_q;
  logic [15:0]   frame_cnt_q;

  logic          skid_ready;
  logic          acc;
  logic          push;
  logic [WIDTH+2:0] push_data;
  logic [WIDTH+2:0] skid_out;
  logic [1:0]    mode_eff;
  logic [1:0]    cur_mode;
  logic [12:0]   cur_nb;
  logic          at_last;
  logic          early_last;

  // Handshakes: a beat moves on either port exactly when tvalid && tready at a rising
  // edge; a producer holds tdata/tlast/tuser stable and tvalid high until it moves.
  always_comb begin
    acc        = s_axis_tvalid && skid_ready && (state_q != PAD);
    mode_eff   = (mode == MODE_RSVD) ? MODE_1024 : mode;
    cur_mode   = (state_q == IDLE) ? mode_eff : mode_q;
    cur_nb     = nb_of(cur_mode, WIDTH);
    at_last    = (cnt_q == cur_nb - 13'd1);
    early_last = USE_TLAST && s_axis_tlast && !at_last;
    push       = 1'b0;
    push_data  = '0;
    if (state_q == PAD) begin
      push      = skid_ready;
      push_data = {{WIDTH{1'b0}}, at_last, mode_q};
    end else if (acc) begin
      push      = 1'b1;
      push_data = {s_axis_tdata, at_last, cur_mode};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mode_q      <= MODE_1024;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      err_mode_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      err_mode_q  <= 1'b0;
      case (state_q)
        IDLE, PASS: begin
          if (acc) begin
            if (state_q == IDLE) begin
              mode_q     <= mode_eff;
              err_mode_q <= (mode == MODE_RSVD);
            end
            if (at_last) begin
              cnt_q       <= '0;
              state_q     <= IDLE;
              frame_cnt_q <= frame_cnt_q + 16'd1;
              err_long_q  <= USE_TLAST && !s_axis_tlast;
            end else begin
              cnt_q <= cnt_q + 13'd1;
              if (early_last) begin
                err_short_q <= 1'b1;
                state_q     <= PAD;
              end else begin
                state_q <= PASS;
              end
            end
          end
        end
        PAD: begin
          if (push) begin
            if (at_last) begin
              cnt_q       <= '0;
              state_q     <= IDLE;
              frame_cnt_q <= frame_cnt_q + 16'd1;
            end else begin
              cnt_q <= cnt_q + 13'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  axis_skid_buffer #(
    .DW(WIDTH + 3)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .in_data_i   (push_data),
    .in_valid_i  (push),
    .in_ready_o  (skid_ready),
    .out_data_o  (skid_out),
    .out_valid_o (m_axis_tvalid),
    .out_ready_i (m_axis_tready)
  );

  assign {m_axis_tdata, m_axis_tlast, m_axis_tuser} = skid_out;
  assign s_axis_tready = skid_ready && (state_q != PAD);
  assign err_short     = err_short_q;
  assign err_long      = err_long_q;
  assign err_mode      = err_mode_q;
  assign frame_cnt     = frame_cnt_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_ccsds_ldpc_axis_framer.sv
// Directed bench for the LDPC input framer: scoreboard of expected output beats plus
// pulse/counter checks, with a second instance built without tlast handling.
`timescale 1ns/1ps
module tb_ccsds_ldpc_axis_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [1:0] mode = 2'd0;
  logic [7:0] s_tdata = '0;
  logic       s_tvalid = 1'b0;
  logic       s_tlast = 1'b0;
  logic       s_tready;
  logic [7:0] m_tdata;
  logic       m_tvalid, m_tlast;
  logic [1:0] m_tuser;
  logic       m_tready;
  logic       err_short, err_long, err_mode;
  logic [15:0] frame_cnt;
  logic [1:0] dbg_state;

  logic       tog_en = 1'b0;
  logic       tog_rdy = 1'b1;
  logic       rdy_man = 1'b1;
  int         tog_cnt = 0;
  assign m_tready = tog_en ? tog_rdy : rdy_man;

  logic [1:0] mode0 = 2'd0;
  logic [7:0] s0_tdata = '0;
  logic       s0_tvalid = 1'b0;
  logic       s0_tlast = 1'b0;
  logic       s0_tready;
  logic [7:0] m0_tdata;
  logic       m0_tvalid, m0_tlast;
  logic [1:0] m0_tuser;
  logic       m0_tready = 1'b1;
  logic       err_short0, err_long0, err_mode0;
  logic [15:0] frame_cnt0;
  logic [1:0] dbg_state0;

  ccsds_ldpc_axis_framer #(.WIDTH(8), .USE_TLAST(1'b1)) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
    .m_axis_tuser(m_tuser), .m_axis_tready(m_tready),
    .err_short(err_short), .err_long(err_long), .err_mode(err_mode),
    .frame_cnt(frame_cnt), .dbg_state(dbg_state)
  );

  ccsds_ldpc_axis_framer #(.WIDTH(8), .USE_TLAST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .mode(mode0),
    .s_axis_tdata(s0_tdata), .s_axis_tvalid(s0_tvalid), .s_axis_tlast(s0_tlast),
    .s_axis_tready(s0_tready),
    .m_axis_tdata(m0_tdata), .m_axis_tvalid(m0_tvalid), .m_axis_tlast(m0_tlast),
    .m_axis_tuser(m0_tuser), .m_axis_tready(m0_tready),
    .err_short(err_short0), .err_long(err_long0), .err_mode(err_mode0),
    .frame_cnt(frame_cnt0), .dbg_state(dbg_state0)
  );

  always @(posedge clk) begin
    #1;
    if (!tog_en) begin
      tog_cnt = 0;
      tog_rdy = 1'b1;
    end else begin
      tog_cnt++;
      if (tog_cnt == 3) begin
        tog_cnt = 0;
        tog_rdy = !tog_rdy;
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  logic [10:0] exp_q[$];
  int acc_n = 0;
  int n_short = 0, n_long = 0, n_mode = 0;
  int short_at = -1, long_at = -1;
  int out0_n = 0, last0_at = -1, bad0 = 0, n_long0 = 0, n_short0 = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void push_exp(input logic [7:0] d, input logic l, input logic [1:0] u);
    exp_q.push_back({d, l, u});
  endfunction

  always @(negedge clk) begin : mon
    logic [10:0] e;
    if (m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        check("out_beat_expected", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check("out_beat", {m_tdata, m_tlast, m_tuser}, e);
      end
    end
    if (err_short) begin n_short++; short_at = acc_n - 1; end
    if (err_long)  begin n_long++;  long_at  = acc_n - 1; end
    if (err_mode)  n_mode++;
  end

  always @(negedge clk) begin : mon0
    if (m0_tvalid && m0_tready) begin
      if (m0_tlast && last0_at < 0) last0_at = out0_n;
      if (m0_tdata !== out0_n[7:0] || m0_tuser !== 2'd0) bad0++;
      out0_n++;
    end
    if (err_long0)  n_long0++;
    if (err_short0) n_short0++;
  end

  task automatic send_beat(input logic [7:0] d, input logic l);
    int n;
    s_tdata = d;
    s_tlast = l;
    s_tvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_tready && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (n >= 300) check("s_tready_timeout", n, 0);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    acc_n++;
  endtask

  task automatic send_beat0(input logic [7:0] d);
    int n;
    s0_tdata = d;
    s0_tvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s0_tready && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (n >= 300) check("s0_tready_timeout", n, 0);
    @(posedge clk);
    #1;
    s0_tvalid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(tag, exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int rdy_bad;
    // reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_s_tready", s_tready, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_s_tready", s_tready, 1);

    // 1: mode 0, full frame, 1-clk latency
    mode = 2'd0;
    check("lat_idle_valid", m_tvalid, 0);
    for (int i = 0; i < 128; i++) begin
      push_exp(i[7:0], i == 127, 2'd0);
      send_beat(i[7:0], i == 127);
      if (i == 0) begin
        check("lat_1clk_valid", m_tvalid, 1);
        check("lat_1clk_data", m_tdata, 8'h00);
      end
    end
    drain("t1_drain");
    check("t1_frame_cnt", frame_cnt, 1);
    check("t1_no_err", n_short + n_long + n_mode, 0);

    // 2: mode 2 then mode 1 under toggling back-pressure
    tog_en = 1'b1;
    mode = 2'd2;
    for (int i = 0; i < 892; i++) begin
      push_exp(i[7:0], i == 891, 2'd2);
      send_beat(i[7:0], i == 891);
    end
    mode = 2'd1;
    for (int i = 0; i < 512; i++) begin
      push_exp(i[7:0] ^ 8'h5A, i == 511, 2'd1);
      send_beat(i[7:0] ^ 8'h5A, i == 511);
    end
    drain("t2_drain");
    tog_en = 1'b0;
    check("t2_frame_cnt", frame_cnt, 3);
    check("t2_no_err", n_short + n_long + n_mode, 0);

    // 3: early tlast on beat 9 -> pad to 128 beats
    mode = 2'd0;
    acc_n = 0;
    for (int i = 0; i < 10; i++) begin
      push_exp((i == 9) ? 8'hA5 : i[7:0], 1'b0, 2'd0);
      send_beat((i == 9) ? 8'hA5 : i[7:0], i == 9);
    end
    for (int i = 10; i < 128; i++) push_exp(8'h00, i == 127, 2'd0);
    check("t3_pad_state", dbg_state, 2);
    rdy_bad = 0;
    repeat (110) begin
      @(negedge clk);
      if (s_tready) rdy_bad++;
    end
    check("t3_pad_s_tready_low", rdy_bad, 0);
    @(posedge clk);
    #1;
    drain("t3_drain");
    check("t3_err_short_cnt", n_short, 1);
    check("t3_err_short_beat", short_at, 9);
    check("t3_frame_cnt", frame_cnt, 4);
    check("t3_s_tready_back", s_tready, 1);

    // 4: missing tlast -> err_long on beat 127, stream continues into frame 2
    acc_n = 0;
    for (int i = 0; i < 256; i++) begin
      push_exp(i[7:0], (i == 127) || (i == 255), 2'd0);
      send_beat(i[7:0], i == 255);
      if (i == 129) check("t4_frame2_state", dbg_state, 1);
    end
    drain("t4_drain");
    check("t4_err_long_cnt", n_long, 1);
    check("t4_err_long_beat", long_at, 127);
    check("t4_frame_cnt", frame_cnt, 6);
    check("t4_no_short", n_short, 1);

    // 4b: same stimulus on the count-only instance
    for (int i = 0; i < 130; i++) send_beat0(i[7:0]);
    repeat (5) @(posedge clk);
    #1;
    check("t4b_out_beats", out0_n, 130);
    check("t4b_tlast_beat", last0_at, 127);
    check("t4b_data", bad0, 0);
    check("t4b_no_err_long", n_long0, 0);
    check("t4b_no_err_short", n_short0, 0);
    check("t4b_no_err_mode", err_mode0, 0);
    check("t4b_frame_cnt", frame_cnt0, 1);
    check("t4b_state_pass", dbg_state0, 1);

    // 5: reserved mode runs as mode 0; mid-frame mode change ignored
    mode = 2'd3;
    for (int i = 0; i < 128; i++) begin
      if (i == 50) mode = 2'd1;
      push_exp(i[7:0] ^ 8'hC3, i == 127, 2'd0);
      send_beat(i[7:0] ^ 8'hC3, i == 127);
    end
    drain("t5_drain");
    check("t5_err_mode_cnt", n_mode, 1);
    check("t5_frame_cnt", frame_cnt, 7);
    check("t5_other_err", n_short + n_long, 2);

    // 6: reset mid-frame in mode 1
    mode = 2'd1;
    for (int i = 0; i < 60; i++) begin
      push_exp(i[7:0], 1'b0, 2'd1);
      send_beat(i[7:0], 1'b0);
    end
    rst = 1'b1;
    s_tdata = 8'd60;
    s_tvalid = 1'b1;
    @(posedge clk);
    #1;
    check("t6_m_tvalid", m_tvalid, 0);
    check("t6_m_tdata", m_tdata, 0);
    check("t6_m_tlast", m_tlast, 0);
    check("t6_m_tuser", m_tuser, 0);
    check("t6_s_tready", s_tready, 0);
    check("t6_errs", {err_short, err_long, err_mode}, 0);
    check("t6_frame_cnt", frame_cnt, 0);
    check("t6_state", dbg_state, 0);
    check("t6_delivered", exp_q.size(), 0);
    rst = 1'b0;
    s_tvalid = 1'b0;
    @(posedge clk);
    #1;
    check("t6_s_tready_after", s_tready, 1);
    mode = 2'd0;
    for (int i = 0; i < 128; i++) begin
      push_exp(i[7:0] ^ 8'h3C, i == 127, 2'd0);
      send_beat(i[7:0] ^ 8'h3C, i == 127);
    end
    drain("t6_drain");
    check("t6_frame_cnt_new", frame_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
